// File: rtl/arinc_scan_reader.sv
// Frame-strobed scanner that reads the six ARINC429 receive RAMs in channel/word order
// and streams the words, tagged with channel and word index, through a small credit-guarded FIFO.
module arinc_scan_reader #(
    parameter int         WORDS      = 32,
    parameter int         RD_LAT     = 2,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [5:0] CH_MASK    = 6'b111111
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [4:0]  rd_arinc1,
    output logic [4:0]  rd_arinc2,
    output logic [4:0]  rd_arinc3,
    output logic [4:0]  rd_arinc4,
    output logic [4:0]  rd_arinc5,
    output logic [4:0]  rd_arinc6,
    input  logic [15:0] arinc_1_outp,
    input  logic [15:0] arinc_2_outp,
    input  logic [15:0] arinc_3_outp,
    input  logic [15:0] arinc_4_outp,
    input  logic [15:0] arinc_5_outp,
    input  logic [15:0] arinc_6_outp,
    output logic [15:0] out_data,
    output logic [2:0]  out_chan,
    output logic [4:0]  out_word,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    function automatic logic [2:0] lowest_en(input logic [5:0] m);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 5; i >= 0; i--) begin
            if (m[i]) r = 3'(i);
        end
        return r;
    endfunction

    function automatic logic [2:0] highest_en(input logic [5:0] m);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 6; i++) begin
            if (m[i]) r = 3'(i);
        end
        return r;
    endfunction

    function automatic logic [2:0] next_en(input logic [2:0] c, input logic [5:0] m);
        logic [2:0] r;
        r = c;
        for (int i = 5; i >= 0; i--) begin
            if (m[i] && (3'(i) > c)) r = 3'(i);
        end
        return r;
    endfunction

    localparam logic [2:0] FIRST_CH  = lowest_en(CH_MASK);
    localparam logic [2:0] LAST_CH   = highest_en(CH_MASK);
    localparam logic [4:0] LAST_WORD = 5'(WORDS - 1);

    state_t          r_state;
    state_t          w_state_nx;
    logic [2:0]      r_chan;
    logic [4:0]      r_word;
    logic [2:0]      w_cur_chan;
    logic [4:0]      w_cur_word;
    logic            w_last;
    logic            w_issue;
    logic            w_credit;
    logic [2:0]      w_inflight;
    logic [7:0]      w_used;
    logic [4:0]      r_rd [6];
    logic [RD_LAT-1:0] r_pv;
    logic [2:0]      r_pc [RD_LAT];
    logic [4:0]      r_pw [RD_LAT];
    logic [15:0]     r_fd [FIFO_DEPTH];
    logic [2:0]      r_fc [FIFO_DEPTH];
    logic [4:0]      r_fw [FIFO_DEPTH];
    logic [AW-1:0]   r_wp;
    logic [AW-1:0]   r_rp;
    logic [CW-1:0]   r_cnt;
    logic            w_push;
    logic            w_pop;
    logic [15:0]     w_cap_data;
    logic            r_busy;
    logic            r_done;

    // In IDLE the first read of a scan is issued on the start edge itself.
    always_comb begin
        if (r_state == S_IDLE) begin
            w_cur_chan = FIRST_CH;
            w_cur_word = 5'd0;
        end else begin
            w_cur_chan = r_chan;
            w_cur_word = r_word;
        end
    end

    assign w_last = (w_cur_word == LAST_WORD) && (w_cur_chan == LAST_CH);

    // Reads still travelling through the RAM pipeline reserve FIFO space.
    always_comb begin
        w_inflight = 3'd0;
        for (int i = 0; i < RD_LAT; i++) begin
            w_inflight = w_inflight + {2'b00, r_pv[i]};
        end
    end

    assign w_used   = 8'(r_cnt) + 8'(w_inflight);
    assign w_credit = (w_used < 8'(FIFO_DEPTH));
    assign w_push   = r_pv[RD_LAT-1];
    assign w_pop    = (r_cnt != CW'(0)) && out_ready;

    // Next-state and issue decision.
    always_comb begin
        w_state_nx = r_state;
        w_issue    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (CH_MASK == 6'd0) begin
                        w_state_nx = S_DONE;
                    end else begin
                        w_issue    = 1'b1;
                        w_state_nx = w_last ? S_DRAIN : S_ISSUE;
                    end
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (w_credit) begin
                    w_issue    = 1'b1;
                    w_state_nx = w_last ? S_DRAIN : S_ISSUE;
                end else begin
                    w_state_nx = S_ISSUE;
                end
            end
            S_DRAIN: begin
                // Leave as the final word is accepted so done follows it by one cycle.
                if ((w_inflight == 3'd0) &&
                    ((r_cnt == CW'(0)) || ((r_cnt == CW'(1)) && out_ready))) begin
                    w_state_nx = S_DONE;
                end else begin
                    w_state_nx = S_DRAIN;
                end
            end
            S_DONE:  w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Registered status outputs decoded from the next state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_state_nx == S_ISSUE) || (w_state_nx == S_DRAIN);
            r_done <= (w_state_nx == S_DONE);
        end
    end

    // Scan position and RAM address drive; only the addressed channel is non-zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_chan <= 3'd0;
            r_word <= 5'd0;
            for (int c = 0; c < 6; c++) r_rd[c] <= 5'd0;
        end else if (w_issue) begin
            for (int c = 0; c < 6; c++) begin
                r_rd[c] <= (3'(c) == w_cur_chan) ? w_cur_word : 5'd0;
            end
            if (w_cur_word == LAST_WORD) begin
                r_word <= 5'd0;
                r_chan <= next_en(w_cur_chan, CH_MASK);
            end else begin
                r_word <= w_cur_word + 5'd1;
                r_chan <= w_cur_chan;
            end
        end
    end

    // Tag pipeline aligned with the RAM read latency.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pv <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                r_pc[i] <= 3'd0;
                r_pw[i] <= 5'd0;
            end
        end else begin
            r_pv[0] <= w_issue;
            r_pc[0] <= w_cur_chan;
            r_pw[0] <= w_cur_word;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pc[i] <= r_pc[i-1];
                r_pw[i] <= r_pw[i-1];
            end
        end
    end

    always_comb begin
        case (r_pc[RD_LAT-1])
            3'd0:    w_cap_data = arinc_1_outp;
            3'd1:    w_cap_data = arinc_2_outp;
            3'd2:    w_cap_data = arinc_3_outp;
            3'd3:    w_cap_data = arinc_4_outp;
            3'd4:    w_cap_data = arinc_5_outp;
            3'd5:    w_cap_data = arinc_6_outp;
            default: w_cap_data = 16'd0;
        endcase
    end

    // Output FIFO; credit on issue guarantees a push never meets a full buffer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wp  <= AW'(0);
            r_rp  <= AW'(0);
            r_cnt <= CW'(0);
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fd[i] <= 16'd0;
                r_fc[i] <= 3'd0;
                r_fw[i] <= 5'd0;
            end
        end else begin
            if (w_push) begin
                r_fd[r_wp] <= w_cap_data;
                r_fc[r_wp] <= r_pc[RD_LAT-1];
                r_fw[r_wp] <= r_pw[RD_LAT-1];
                r_wp       <= r_wp + AW'(1);
            end
            if (w_pop) begin
                r_rp <= r_rp + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign out_valid = (r_cnt != CW'(0));
    assign out_data  = r_fd[r_rp];
    assign out_chan  = r_fc[r_rp];
    assign out_word  = r_fw[r_rp];
    assign rd_arinc1 = r_rd[0];
    assign rd_arinc2 = r_rd[1];
    assign rd_arinc3 = r_rd[2];
    assign rd_arinc4 = r_rd[3];
    assign rd_arinc5 = r_rd[4];
    assign rd_arinc6 = r_rd[5];

endmodule

// File: tb/tb_arinc_scan_reader.sv
// Directed bench for arinc_scan_reader: four parameterisations, each fed by RAM models of
// matching read latency preloaded with {chan, 7'b0, addr}.
module tb_arinc_scan_reader;

    localparam int         LAT_T   [4] = '{2, 3, 1, 2};
    localparam int         WORDS_T [4] = '{32, 3, 4, 32};
    localparam logic [5:0] MASK_T  [4] = '{6'b111111, 6'b100101, 6'b001010, 6'b000000};

    logic         clk;
    logic [3:0]   rst_v;
    logic [3:0]   st_v;
    logic [3:0]   rdy_v;
    wire  [3:0]   busy_v;
    wire  [3:0]   done_v;
    wire  [3:0]   valid_v;
    wire  [11:0]  chan_v;
    wire  [19:0]  word_v;
    wire  [63:0]  data_v;
    wire  [119:0] addr_v;
    int           cyc;
    int           n_chk;
    int           n_pass;

    function automatic logic [15:0] ram_word(input int c, input logic [4:0] a);
        return {4'(c), 7'b0000000, a};
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_dut
        logic [4:0]  d1 [6];
        logic [4:0]  d2 [6];
        logic [15:0] q  [6];

        always @(posedge clk) begin
            for (int c = 0; c < 6; c++) begin
                d1[c] <= addr_v[g*30 + c*5 +: 5];
                d2[c] <= d1[c];
            end
        end

        always_comb begin
            for (int c = 0; c < 6; c++) begin
                if (LAT_T[g] == 1)      q[c] = ram_word(c, addr_v[g*30 + c*5 +: 5]);
                else if (LAT_T[g] == 2) q[c] = ram_word(c, d1[c]);
                else                    q[c] = ram_word(c, d2[c]);
            end
        end

        arinc_scan_reader #(
            .WORDS(WORDS_T[g]), .RD_LAT(LAT_T[g]), .FIFO_DEPTH(4), .CH_MASK(MASK_T[g])
        ) u_dut (
            .clock(clk), .reset(rst_v[g]), .start(st_v[g]),
            .busy(busy_v[g]), .done(done_v[g]),
            .rd_arinc1(addr_v[g*30 +  0 +: 5]), .rd_arinc2(addr_v[g*30 +  5 +: 5]),
            .rd_arinc3(addr_v[g*30 + 10 +: 5]), .rd_arinc4(addr_v[g*30 + 15 +: 5]),
            .rd_arinc5(addr_v[g*30 + 20 +: 5]), .rd_arinc6(addr_v[g*30 + 25 +: 5]),
            .arinc_1_outp(q[0]), .arinc_2_outp(q[1]), .arinc_3_outp(q[2]),
            .arinc_4_outp(q[3]), .arinc_5_outp(q[4]), .arinc_6_outp(q[5]),
            .out_data(data_v[g*16 +: 16]), .out_chan(chan_v[g*3 +: 3]),
            .out_word(word_v[g*5 +: 5]), .out_valid(valid_v[g]), .out_ready(rdy_v[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        else n_pass++;
    endtask

    // One scan on DUT k: bp = random backpressure, restart = extra start at beat 10,
    // rst_at > 0 = abort with reset after that many beats, st_len = cycles start is held.
    task automatic run_scan(input int k, input logic [5:0] mask, input int words, input int lat,
                            input bit bp, input bit restart, input int rst_at, input int st_len);
        logic [23:0] exp_q [$];
        logic [29:0] addr_or;
        logic [29:0] unused_or;
        int n, n_done, s, st_until, first_cyc, last_cyc, done_cyc, post_done;
        bit restarted;
        for (int c = 0; c < 6; c++) begin
            if (mask[c]) begin
                for (int w = 0; w < words; w++) exp_q.push_back({3'(c), 5'(w), ram_word(c, 5'(w))});
            end
        end
        n = 0; n_done = 0; first_cyc = -1; last_cyc = -1; done_cyc = -1; post_done = 0;
        restarted = 1'b0; addr_or = '0;
        rdy_v[k] = 1'b1;
        st_v[k]  = 1'b1;
        s = cyc;
        st_until = s + st_len;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            addr_or = addr_or | addr_v[k*30 +: 30];
            if (valid_v[k] && first_cyc < 0) first_cyc = cyc;
            if (valid_v[k] && rdy_v[k]) begin
                if (n < exp_q.size())
                    check_eq("beat", {8'h00, chan_v[k*3 +: 3], word_v[k*5 +: 5], data_v[k*16 +: 16]},
                             {8'h00, exp_q[n]});
                else
                    check_eq("beat_count_overrun", n, exp_q.size());
                n++;
                last_cyc = cyc;
            end
            if (done_v[k]) begin
                n_done++;
                done_cyc = cyc;
                check_eq("busy_low_at_done", busy_v[k], 1'b0);
            end
            if (n_done > 0) post_done++;
            @(posedge clk);
            #1;
            st_v[k] = (cyc < st_until);
            if (restart && !restarted && n >= 10) begin
                restarted = 1'b1;
                check_eq("busy_during_scan", busy_v[k], 1'b1);
                st_v[k] = 1'b1;
                st_until = cyc + 1;
            end
            if (bp) rdy_v[k] = ($urandom_range(0, 9) >= 3);
            if (rst_at > 0 && n >= rst_at) begin
                rdy_v[k] = 1'b0;
                rst_v[k] = 1'b1;
                #1;
                check_eq("rst_valid", valid_v[k], 1'b0);
                check_eq("rst_busy", busy_v[k], 1'b0);
                check_eq("rst_data", data_v[k*16 +: 16], 16'h0000);
                check_eq("rst_addr", addr_v[k*30 +: 30], 30'h0);
                @(posedge clk);
                #1;
                rst_v[k] = 1'b0;
                n_done = 0;
                for (int j = 0; j < 10; j++) begin
                    @(negedge clk);
                    if (done_v[k] || valid_v[k]) n_done++;
                end
                check_eq("quiet_after_reset", n_done, 0);
                @(posedge clk);
                #1;
                rdy_v[k] = 1'b1;
                return;
            end
            if (post_done >= 4) break;
        end
        st_v[k] = 1'b0;
        rdy_v[k] = 1'b1;
        check_eq("beat_total", n, exp_q.size());
        check_eq("done_pulses", n_done, 1);
        check_eq("busy_after_scan", busy_v[k], 1'b0);
        if (exp_q.size() > 0) begin
            check_eq("first_valid_latency", first_cyc - s, lat + 1);
            check_eq("done_after_last_beat", done_cyc - last_cyc, 1);
        end else begin
            check_eq("done_latency_empty_mask", done_cyc - s, 1);
            check_eq("no_valid_empty_mask", first_cyc, -1);
        end
        if (mask != 6'b111111) begin
            unused_or = '0;
            for (int c = 0; c < 6; c++) begin
                if (!mask[c]) unused_or[c*5 +: 5] = addr_or[c*5 +: 5];
            end
            check_eq("disabled_addr_zero", unused_or, 30'h0);
        end
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst_v  = 4'hF;
        st_v   = 4'h0;
        rdy_v  = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_valid", {28'h0, valid_v}, 32'h0);
        check_eq("reset_busy", {28'h0, busy_v}, 32'h0);
        check_eq("reset_done", {28'h0, done_v}, 32'h0);
        check_eq("reset_data", {31'h0, |data_v}, 32'h0);
        check_eq("reset_tags", {12'h0, chan_v, word_v}, 32'h0);
        check_eq("reset_addr", {31'h0, |addr_v}, 32'h0);
        rst_v = 4'h0;
        @(posedge clk);
        #1;
        run_scan(0, 6'b111111, 32, 2, 1'b0, 1'b0, 0, 1);
        run_scan(0, 6'b111111, 32, 2, 1'b1, 1'b0, 0, 1);
        run_scan(0, 6'b111111, 32, 2, 1'b0, 1'b1, 0, 1);
        run_scan(0, 6'b111111, 32, 2, 1'b0, 1'b0, 50, 1);
        run_scan(0, 6'b111111, 32, 2, 1'b0, 1'b0, 0, 1);
        run_scan(1, 6'b100101, 3, 3, 1'b0, 1'b0, 0, 1);
        run_scan(1, 6'b100101, 3, 3, 1'b1, 1'b0, 0, 1);
        run_scan(2, 6'b001010, 4, 1, 1'b0, 1'b0, 0, 1);
        run_scan(3, 6'b000000, 32, 2, 1'b0, 1'b0, 0, 2);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
